// File: rtl/pwm_ramp_ctrl_if.sv
// Handshake and status bundle for pwm_ramp_ctrl.
//   cmd_valid/cmd_target/cmd_ready : ramp command handshake
//   inc_pulse/dec_pulse            : single-cycle debounced step requests
//   duty/busy/period_start/pwm_out : applied duty and PWM status
// master drives requests; slave is the controller.
interface pwm_ramp_ctrl_if #(
  parameter int DUTY_W = 4
);
  logic              cmd_valid;
  logic [DUTY_W-1:0] cmd_target;
  logic              cmd_ready;
  logic              inc_pulse;
  logic              dec_pulse;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              period_start;
  logic              pwm_out;

  modport master (
    output cmd_valid, cmd_target, inc_pulse, dec_pulse,
    input  cmd_ready, duty, busy, period_start, pwm_out
  );

  modport slave (
    input  cmd_valid, cmd_target, inc_pulse, dec_pulse,
    output cmd_ready, duty, busy, period_start, pwm_out
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer and PWM generator.
// Owns the PWM period counter and the applied duty register. Duty changes
// come from a ramp command (target, stepped once every STEP_DIV periods) or
// from debounced inc/dec pulses; every change is applied on the edge that
// ends the last cycle of a period, so pwm_out never glitches mid-period.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pwm_ramp_ctrl_if slave (command handshake, pulses, status)
module pwm_ramp_ctrl #(
  parameter int PERIOD   = 10,
  parameter int DUTY_W   = 4,
  parameter int STEP_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_ramp_ctrl_if.slave  bus
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_HALF = DUTY_W'(PERIOD / 2);
  localparam logic [SW-1:0]     STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state, state_n;
  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] duty, duty_n;
  logic [DUTY_W-1:0] target, target_n;
  logic [SW-1:0]     step_cnt, step_n;
  logic              inc_pend, inc_n;
  logic              dec_pend, dec_n;
  logic              pwm_q;

  logic              wrap;
  logic [DUTY_W-1:0] cmd_clamped;
  logic              inc_req, dec_req;
  logic [DUTY_W-1:0] ramp_next;

  assign wrap        = (cnt == CNT_LAST);
  assign cmd_clamped = (bus.cmd_target > DUTY_MAX) ? DUTY_MAX : bus.cmd_target;
  assign inc_req     = inc_pend | bus.inc_pulse;
  assign dec_req     = dec_pend | bus.dec_pulse;
  assign ramp_next   = (duty < target) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);

  assign bus.duty         = duty;
  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = (cnt == '0);
  assign bus.cmd_ready    = (state == IDLE);
  assign bus.busy         = (state == RAMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      duty     <= DUTY_HALF;
      target   <= DUTY_HALF;
      step_cnt <= '0;
      inc_pend <= 1'b0;
      dec_pend <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= wrap ? '0 : cnt + DUTY_W'(1);
      duty     <= duty_n;
      target   <= target_n;
      step_cnt <= step_n;
      inc_pend <= inc_n;
      dec_pend <= dec_n;
      pwm_q    <= (cnt < duty);
    end
  end

  always_comb begin
    state_n  = state;
    duty_n   = duty;
    target_n = target;
    step_n   = step_cnt;
    inc_n    = inc_pend;
    dec_n    = dec_pend;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          // Command wins over any same-cycle or pending pulse.
          target_n = cmd_clamped;
          step_n   = '0;
          inc_n    = 1'b0;
          dec_n    = 1'b0;
          if (cmd_clamped != duty) state_n = RAMP;
        end else if (wrap) begin
          // A pulse on the wrap cycle itself is applied at this edge; opposing
          // requests within one period cancel.
          if (inc_req && !dec_req && duty != DUTY_MAX) duty_n = duty + DUTY_W'(1);
          if (dec_req && !inc_req && duty != '0)       duty_n = duty - DUTY_W'(1);
          inc_n = 1'b0;
          dec_n = 1'b0;
        end else begin
          inc_n = inc_req;
          dec_n = dec_req;
        end
      end

      RAMP: begin
        // Pulses are dropped here; only the step divider advances.
        if (wrap) begin
          if (step_cnt == STEP_LAST) begin
            step_n = '0;
            duty_n = ramp_next;
            if (ramp_next == target) state_n = IDLE;
          end else begin
            step_n = step_cnt + SW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl (PERIOD=10, DUTY_W=4, STEP_DIV=4).
// Expected duty steps are queued when a command or pulse is driven and
// popped as the DUT applies each change.
module tb_pwm_ramp_ctrl;

  localparam int PERIOD   = 10;
  localparam int STEP_DIV = 4;
  localparam int STEP_CYC = PERIOD * STEP_DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_ramp_ctrl_if #(.DUTY_W(4)) bus();

  pwm_ramp_ctrl #(
    .PERIOD(PERIOD),
    .DUTY_W(4),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  // Independent period phase: equals the DUT counter value at each negedge.
  logic [3:0] tcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 4'd0;
    else        tcnt <= (tcnt == 4'd9) ? 4'd0 : tcnt + 4'd1;
  end

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 4'd0;
    bus.inc_pulse  = 1'b0;
    bus.dec_pulse  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_duty_change(input int budget, output int n, output bit ok);
    logic [3:0] prev;
    prev = bus.duty;
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (bus.duty !== prev) ok = 1'b1;
    end
  endtask

  task automatic wait_phase(input logic [3:0] ph);
    @(negedge clk);
    while (tcnt !== ph) @(negedge clk);
  endtask

  // Caller sits at a negedge; the following posedge is the handshake edge.
  task automatic send_cmd(input logic [3:0] tgt, input bit with_inc);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt;
    bus.inc_pulse  = with_inc;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic pulse(input bit inc);
    if (inc) bus.inc_pulse = 1'b1;
    else     bus.dec_pulse = 1'b1;
    @(negedge clk);
    bus.inc_pulse = 1'b0;
    bus.dec_pulse = 1'b0;
  endtask

  task automatic push_ramp(input int from, input int to);
    int t;
    t = (to > PERIOD) ? PERIOD : to;
    while (from != t) begin
      from = (from < t) ? from + 1 : from - 1;
      exp_q.push_back(4'(from));
    end
  endtask

  task automatic follow_ramp(input string tag, input int steps, input bit space_first, input bit ends);
    int n;
    bit ok;
    logic [3:0] e;
    bit eb;
    for (int i = 0; i < steps; i++) begin
      wait_duty_change(STEP_CYC + 20, n, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL %s step %0d timeout: duty stuck at %0d, required a change within %0d cycles",
                 tag, i, bus.duty, STEP_CYC + 20);
        exp_q.delete();
        return;
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s step %0d: unexpected duty change to %0d, none queued", tag, i, bus.duty);
        return;
      end
      e = exp_q.pop_front();
      if (bus.duty !== e) begin
        miscompares++;
        $display("FAIL %s step %0d duty: got %0d, required %0d", tag, i, bus.duty, e);
      end
      vectors++;
      if (tcnt !== 4'd0 || bus.period_start !== 1'b1) begin
        miscompares++;
        $display("FAIL %s step %0d boundary: cnt=%0d period_start=%b, required cnt=0 period_start=1",
                 tag, i, tcnt, bus.period_start);
      end
      if (i > 0 || space_first) begin
        vectors++;
        if (n !== STEP_CYC) begin
          miscompares++;
          $display("FAIL %s step %0d spacing: got %0d cycles, required %0d", tag, i, n, STEP_CYC);
        end
      end
      eb = !(ends && i == steps - 1);
      vectors++;
      if (bus.busy !== eb || bus.cmd_ready !== !eb) begin
        miscompares++;
        $display("FAIL %s step %0d status: busy=%b cmd_ready=%b, required busy=%b cmd_ready=%b",
                 tag, i, bus.busy, bus.cmd_ready, eb, !eb);
      end
    end
  endtask

  task automatic test_reset();
    logic exp_pwm;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.duty !== 4'd5 || bus.pwm_out !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.period_start !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: duty=%0d pwm=%b ready=%b busy=%b pstart=%b, required 5 0 1 0 1",
               bus.duty, bus.pwm_out, bus.cmd_ready, bus.busy, bus.period_start);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_pwm = ((k % PERIOD) < 5);
      vectors++;
      if (bus.pwm_out !== exp_pwm || bus.period_start !== (tcnt == 4'd0)) begin
        miscompares++;
        $display("FAIL reset_pattern cycle %0d: pwm=%b pstart=%b, required pwm=%b pstart=%b",
                 k, bus.pwm_out, bus.period_start, exp_pwm, (tcnt == 4'd0));
      end
    end
  endtask

  task automatic test_ramp_up();
    int h, n, lat, exp_lat;
    bit ok;
    logic [3:0] e;
    h = int'(tcnt);
    exp_lat = ((h == PERIOD - 1) ? PERIOD + 1 : PERIOD - h) + (STEP_DIV - 1) * PERIOD;
    push_ramp(5, 8);
    send_cmd(4'd8, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_up_enter: busy=%b ready=%b, required 1 0", bus.busy, bus.cmd_ready);
    end
    wait_duty_change(STEP_CYC + 20, n, ok);
    lat = n + 1;
    vectors++;
    if (!ok || lat !== exp_lat) begin
      miscompares++;
      $display("FAIL ramp_up_latency: got %0d edges (changed=%b), required %0d", lat, ok, exp_lat);
    end
    e = exp_q.pop_front();
    vectors++;
    if (bus.duty !== e) begin
      miscompares++;
      $display("FAIL ramp_up_first: duty=%0d, required %0d", bus.duty, e);
    end
    follow_ramp("ramp_up", 2, 1'b1, 1'b1);
  endtask

  task automatic test_clamp_and_down();
    apply_reset();
    push_ramp(5, 15);
    send_cmd(4'd15, 1'b0);
    follow_ramp("clamp_up", 5, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.pwm_out !== 1'b1 || bus.duty !== 4'd10) begin
        miscompares++;
        $display("FAIL clamp_high cycle %0d: pwm=%b duty=%0d, required 1 10", k, bus.pwm_out, bus.duty);
      end
    end
    push_ramp(10, 0);
    send_cmd(4'd0, 1'b0);
    follow_ramp("ramp_down", 10, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.pwm_out !== 1'b0 || bus.duty !== 4'd0) begin
        miscompares++;
        $display("FAIL down_low cycle %0d: pwm=%b duty=%0d, required 0 0", k, bus.pwm_out, bus.duty);
      end
    end
  endtask

  task automatic test_buttons();
    int n;
    bit ok;
    logic [3:0] e;
    apply_reset();
    push_ramp(5, 10);
    send_cmd(4'd10, 1'b0);
    follow_ramp("btn_setup", 5, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      wait_phase(4'(1 + 2 * j));
      pulse(1'b1);
    end
    wait_duty_change(15, n, ok);
    vectors++;
    if (ok || bus.duty !== 4'd10) begin
      miscompares++;
      $display("FAIL inc_saturate: duty=%0d, required 10 unchanged", bus.duty);
    end
    for (int j = 0; j < 3; j++) begin
      wait_phase(4'd2);
      exp_q.push_back(4'(9 - j));
      pulse(1'b0);
      wait_duty_change(2 * PERIOD, n, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || bus.duty !== e || tcnt !== 4'd0) begin
        miscompares++;
        $display("FAIL dec_step %0d: duty=%0d cnt=%0d changed=%b, required duty=%0d cnt=0",
                 j, bus.duty, tcnt, ok, e);
      end
    end
  endtask

  task automatic test_collisions();
    int n;
    bit ok;
    apply_reset();
    wait_phase(4'd1);
    pulse(1'b1);
    wait_phase(4'd3);
    pulse(1'b0);
    wait_duty_change(2 * PERIOD, n, ok);
    vectors++;
    if (ok || bus.duty !== 4'd5) begin
      miscompares++;
      $display("FAIL inc_dec_cancel: duty=%0d, required 5 unchanged", bus.duty);
    end
    push_ramp(5, 7);
    send_cmd(4'd7, 1'b0);
    repeat (5) @(negedge clk);
    pulse(1'b1);
    follow_ramp("ramp_drop_pulse", 2, 1'b0, 1'b1);
    wait_duty_change(STEP_CYC + 5, n, ok);
    vectors++;
    if (ok || bus.duty !== 4'd7) begin
      miscompares++;
      $display("FAIL ramp_pulse_dropped: duty=%0d, required 7 unchanged", bus.duty);
    end
    push_ramp(7, 6);
    send_cmd(4'd6, 1'b1);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_vs_inc_accept: busy=%b, required 1", bus.busy);
    end
    follow_ramp("cmd_vs_inc", 1, 1'b0, 1'b1);
    wait_duty_change(STEP_CYC + 5, n, ok);
    vectors++;
    if (ok || bus.duty !== 4'd6) begin
      miscompares++;
      $display("FAIL cmd_vs_inc_drop: duty=%0d, required 6 unchanged", bus.duty);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    bit ok;
    apply_reset();
    push_ramp(5, 10);
    send_cmd(4'd10, 1'b0);
    follow_ramp("mid_ramp", 2, 1'b0, 1'b0);
    wait_phase(4'd4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (bus.duty !== 4'd5 || bus.pwm_out !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.period_start !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_ramp_reset: duty=%0d pwm=%b ready=%b busy=%b pstart=%b, required 5 0 1 0 1",
               bus.duty, bus.pwm_out, bus.cmd_ready, bus.busy, bus.period_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_duty_change(STEP_CYC + 5, n, ok);
    vectors++;
    if (ok || bus.duty !== 4'd5 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: duty=%0d busy=%b, required 5 0", bus.duty, bus.busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_and_down();
    test_buttons();
    test_collisions();
    test_reset_mid_ramp();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected steps left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
